// File: rtl/pipeexe_md_if.sv
// Purpose: groups the ID/EX operand/control inputs and the EX/MEM outputs of pipeexe_md.
// Latency: none (wiring only).
// Backpressure: stall flows from slave to master and freezes the upstream stages.
// Ports: master = pipeline front end (drives e*, observes stall/m*),
//        slave  = execute stage (consumes e*, produces stall/m*).
interface pipeexe_md_if;
  logic        ewreg;
  logic        em2reg;
  logic        ewmem;
  logic [3:0]  ealuc;
  logic        ealuimm;
  logic        eshift;
  logic        ejal;
  logic [1:0]  emdop;
  logic [31:0] ea;
  logic [31:0] eb;
  logic [31:0] eimm;
  logic [31:0] epc4;
  logic [4:0]  ern0;
  logic        stall;
  logic        mwreg;
  logic        mm2reg;
  logic        mwmem;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [4:0]  mrn;

  modport master (
    output ewreg, em2reg, ewmem, ealuc, ealuimm, eshift, ejal, emdop,
           ea, eb, eimm, epc4, ern0,
    input  stall, mwreg, mm2reg, mwmem, malu, mb, mrn
  );

  modport slave (
    input  ewreg, em2reg, ewmem, ealuc, ealuimm, eshift, ejal, emdop,
           ea, eb, eimm, epc4, ern0,
    output stall, mwreg, mm2reg, mwmem, malu, mb, mrn
  );
endinterface

// File: rtl/pipeexe_md.sv
// Purpose: execute stage (ALU / jal link / iterative mul-divu-remu) with the EX/MEM register.
// Latency: ALU and jal 1 cycle; mul/div results appear 34 edges after acceptance.
// Backpressure: combinational stall holds upstream for 33 cycles per md op; EX/MEM gets bubbles meanwhile.
// Ports: clock, reset (sync, active-high); bus.slave carries ID/EX inputs, stall and EX/MEM outputs.
module pipeexe_md (
  input  logic          clock,
  input  logic          reset,
  pipeexe_md_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [1:0]  op_q;
  // Shared md datapath: mul uses acc=product, x=multiplicand, y=multiplier;
  // divide uses acc=partial remainder, x=dividend shifting into quotient, y=divisor.
  logic [31:0] acc_q;
  logic [31:0] x_q;
  logic [31:0] y_q;

  logic        mwreg_q, mm2reg_q, mwmem_q;
  logic [31:0] malu_q, mb_q;
  logic [4:0]  mrn_q;
  logic        mwreg_d, mm2reg_d, mwmem_d;
  logic [31:0] malu_d, mb_d;
  logic [4:0]  mrn_d;

  logic        stall;
  logic [31:0] alu_a, alu_b, alu_res, alu_sra;

  logic [31:0] mul_acc_nx;
  logic [32:0] rem_sh;
  logic        rem_ge;
  logic [31:0] div_rem_nx;
  logic [31:0] div_quo_nx;
  logic [31:0] md_res;

  // ---------------- ALU ----------------
  assign alu_a   = bus.eshift ? {27'b0, bus.eimm[10:6]} : bus.ea;
  assign alu_b   = bus.ealuimm ? bus.eimm : bus.eb;
  // Kept separate so the arithmetic shift is not turned logical by an unsigned ternary.
  assign alu_sra = $signed(alu_b) >>> alu_a[4:0];

  always_comb begin
    alu_res = '0;
    case (bus.ealuc[2:0])
      3'b000: alu_res = alu_a + alu_b;
      3'b100: alu_res = alu_a - alu_b;
      3'b001: alu_res = alu_a & alu_b;
      3'b101: alu_res = alu_a | alu_b;
      3'b010: alu_res = alu_a ^ alu_b;
      3'b110: alu_res = {alu_b[15:0], 16'b0};
      3'b011: alu_res = alu_b << alu_a[4:0];
      3'b111: alu_res = bus.ealuc[3] ? alu_sra : (alu_b >> alu_a[4:0]);
      default: alu_res = '0;
    endcase
  end

  // ---------------- md iteration ----------------
  assign mul_acc_nx = y_q[0] ? (acc_q + x_q) : acc_q;

  // Restoring divide step. The shifted remainder needs 33 bits; when it is
  // >= divisor the difference is < divisor, so 32-bit subtraction is exact.
  assign rem_sh     = {acc_q, x_q[31]};
  assign rem_ge     = (rem_sh >= {1'b0, y_q});
  assign div_rem_nx = rem_ge ? (rem_sh[31:0] - y_q) : rem_sh[31:0];
  assign div_quo_nx = {x_q[30:0], rem_ge};

  // divu returns the quotient register; mul and remu both finish in acc.
  assign md_res = (op_q == 2'b10) ? x_q : acc_q;

  // ---------------- stall ----------------
  // Forced low while reset is asserted so a held md op cannot stall a block being cleared.
  assign stall = ~reset & (((state_q == IDLE) & (bus.emdop != 2'b00)) | (state_q == BUSY));

  // ---------------- EX/MEM next state ----------------
  always_comb begin
    mwreg_d  = 1'b0;
    mm2reg_d = 1'b0;
    mwmem_d  = 1'b0;
    malu_d   = '0;
    mb_d     = '0;
    mrn_d    = '0;
    if (!stall) begin
      mwreg_d  = bus.ewreg;
      mm2reg_d = bus.em2reg;
      mwmem_d  = bus.ewmem;
      if (bus.ejal) begin
        malu_d = bus.epc4 + 32'd4;
      end else if (state_q == DONE) begin
        malu_d = md_res;
      end else begin
        malu_d = alu_res;
      end
      mb_d  = bus.eb;
      mrn_d = bus.ern0 | {5{bus.ejal}};
    end
  end

  // ---------------- FSM, md datapath and EX/MEM register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
      malu_q   <= '0;
      mb_q     <= '0;
      mrn_q    <= '0;
    end else begin
      mwreg_q  <= mwreg_d;
      mm2reg_q <= mm2reg_d;
      mwmem_q  <= mwmem_d;
      malu_q   <= malu_d;
      mb_q     <= mb_d;
      mrn_q    <= mrn_d;
      case (state_q)
        IDLE: begin
          if (bus.emdop != 2'b00) begin
            op_q    <= bus.emdop;
            x_q     <= bus.ea;
            y_q     <= bus.eb;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (op_q == 2'b01) begin
            acc_q <= mul_acc_nx;
            x_q   <= x_q << 1;
            y_q   <= y_q >> 1;
          end else begin
            acc_q <= div_rem_nx;
            x_q   <= div_quo_nx;
          end
          if (cnt_q == 5'd31) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        // The held md instruction leaves ID/EX at the end of this cycle, so
        // returning to IDLE cannot re-accept it.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall  = stall;
  assign bus.mwreg  = mwreg_q;
  assign bus.mm2reg = mm2reg_q;
  assign bus.mwmem  = mwmem_q;
  assign bus.malu   = malu_q;
  assign bus.mb     = mb_q;
  assign bus.mrn    = mrn_q;

endmodule

// File: tb/tb_pipeexe_md.sv
// Purpose: self-checking bench for pipeexe_md against a behavioural reference model.
// Latency: checks 1-cycle ALU capture and the 33-cycle stall / 34-edge md result timing.
// Backpressure: verifies stall length, bubble insertion and back-to-back md acceptance.
module tb_pipeexe_md;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [31:0] alu;
    logic [31:0] b;
    logic [4:0]  rn;
  } exmem_t;

  pipeexe_md_if bus();

  pipeexe_md dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  exmem_t obs;
  assign obs = {bus.mwreg, bus.mm2reg, bus.mwmem, bus.malu, bus.mb, bus.mrn};

  logic [3:0] codes [15] = '{4'b0000, 4'b1000, 4'b0100, 4'b1100, 4'b0001, 4'b1001,
                             4'b0101, 4'b1101, 4'b0010, 4'b1010, 4'b0110, 4'b1110,
                             4'b0011, 4'b0111, 4'b1111};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ewreg = 0; bus.em2reg = 0; bus.ewmem = 0; bus.ealuc = 4'b0000;
    bus.ealuimm = 0; bus.eshift = 0; bus.ejal = 0; bus.emdop = 2'b00;
    bus.ea = 0; bus.eb = 0; bus.eimm = 0; bus.epc4 = 0; bus.ern0 = 0;
  endtask

  task automatic drive_rand_alu();
    bus.ewreg   = 1'($urandom_range(0, 1));
    bus.em2reg  = 1'($urandom_range(0, 1));
    bus.ewmem   = 1'($urandom_range(0, 1));
    bus.ealuc   = codes[$urandom_range(0, 14)];
    bus.ealuimm = 1'($urandom_range(0, 1));
    bus.eshift  = 1'($urandom_range(0, 1));
    bus.ejal    = ($urandom_range(0, 7) == 0);
    bus.emdop   = 2'b00;
    bus.ea      = $urandom;
    bus.eb      = $urandom;
    bus.eimm    = $urandom;
    bus.epc4    = $urandom;
    bus.ern0    = 5'($urandom_range(0, 31));
  endtask

  // Reference: what EX/MEM should hold after the edge for the current non-md inputs.
  function automatic exmem_t alu_expect();
    logic [31:0]        a, b, r;
    logic signed [31:0] sb;
    logic [4:0]         amt;
    a   = bus.eshift ? {27'b0, bus.eimm[10:6]} : bus.ea;
    b   = bus.ealuimm ? bus.eimm : bus.eb;
    amt = a[4:0];
    sb  = b;
    case (bus.ealuc)
      4'b0000, 4'b1000: r = a + b;
      4'b0100, 4'b1100: r = a - b;
      4'b0001, 4'b1001: r = a & b;
      4'b0101, 4'b1101: r = a | b;
      4'b0010, 4'b1010: r = a ^ b;
      4'b0110, 4'b1110: r = b * 32'd65536;
      4'b0011:          r = b << amt;
      4'b0111:          r = b >> amt;
      4'b1111:          r = sb >>> amt;
      default:          r = 32'h0;
    endcase
    if (bus.ejal) r = bus.epc4 + 32'd4;
    return {bus.ewreg, bus.em2reg, bus.ewmem, r, bus.eb, (bus.ejal ? 5'd31 : bus.ern0)};
  endfunction

  function automatic logic [31:0] md_expect(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'b01:   return p[31:0];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive_rand_alu();
    bus.emdop = 2'($urandom_range(1, 3));
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, obs);
      end
      vectors++;
      if (bus.stall !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_stall cycle %0d: got %b expected 0", i, bus.stall);
      end
    end
    reset = 1'b0;
    drive_rand_alu();
    begin
      exmem_t exp;
      exp = alu_expect();
      tick();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL reset_first_instr: got %h expected %h", obs, exp);
      end
    end
  endtask

  task automatic test_alu_directed();
    // add with overflow wrap
    clear_inputs();
    bus.ewreg = 1; bus.ea = 32'h7FFF_FFFF; bus.eb = 32'h1; bus.ern0 = 5'd4;
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL alu_no_stall: got %b expected 0", bus.stall);
    end
    tick();
    vectors++;
    if (bus.malu !== 32'h8000_0000 || bus.mrn !== 5'd4 || bus.mwreg !== 1'b1) begin
      miscompares++;
      $display("FAIL add_ovf: got malu=%h mrn=%0d mwreg=%b expected 80000000/4/1", bus.malu, bus.mrn, bus.mwreg);
    end
    // sra by shamt 4
    clear_inputs();
    bus.ealuc = 4'b1111; bus.eshift = 1; bus.eimm = 32'h0000_0100; bus.eb = 32'h8000_0000;
    tick();
    vectors++;
    if (bus.malu !== 32'hF800_0000) begin
      miscompares++;
      $display("FAIL sra: got %h expected f8000000", bus.malu);
    end
    // jal link
    clear_inputs();
    bus.ejal = 1; bus.ewreg = 1; bus.epc4 = 32'h100; bus.ern0 = 5'd5; bus.ea = 32'h55;
    tick();
    vectors++;
    if (bus.malu !== 32'h104 || bus.mrn !== 5'd31) begin
      miscompares++;
      $display("FAIL jal: got malu=%h mrn=%0d expected 104/31", bus.malu, bus.mrn);
    end
    // store address/data
    clear_inputs();
    bus.ewmem = 1; bus.eb = 32'hDEAD_BEEF; bus.ealuimm = 1; bus.ea = 32'h10; bus.eimm = 32'h4;
    tick();
    vectors++;
    if (bus.mwmem !== 1'b1 || bus.malu !== 32'h14 || bus.mb !== 32'hDEAD_BEEF || bus.mwreg !== 1'b0) begin
      miscompares++;
      $display("FAIL store: got mwmem=%b malu=%h mb=%h mwreg=%b expected 1/14/deadbeef/0",
               bus.mwmem, bus.malu, bus.mb, bus.mwreg);
    end
  endtask

  task automatic test_alu_random();
    exmem_t exp;
    for (int i = 0; i < 40; i++) begin
      drive_rand_alu();
      exp = alu_expect();
      tick();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL alu_rand[%0d] aluc=%b: got %h expected %h", i, bus.ealuc, obs, exp);
      end
    end
  endtask

  // Every md op is issued in the cycle right after the previous result edge,
  // so the stall-at-entry check also proves there is no gap cycle.
  task automatic test_md_back_to_back();
    logic [1:0]  ops [$];
    logic [31:0] as [$];
    logic [31:0] bs [$];
    exmem_t      exp;
    int          cnt;
    ops = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b11};
    as  = '{32'hFFFF_FFFF, 32'd100, 32'd100, 32'd5, 32'd5};
    bs  = '{32'd3, 32'd7, 32'd7, 32'd0, 32'd0};
    for (int k = 0; k < 6; k++) begin
      int sel;
      sel = $urandom_range(0, 3);
      ops.push_back(2'($urandom_range(1, 3)));
      as.push_back($urandom);
      bs.push_back(sel == 0 ? 32'd0 : (sel == 1 ? 32'($urandom_range(1, 255)) : $urandom));
    end
    for (int i = 0; i < ops.size(); i++) begin
      drive_rand_alu();
      bus.ejal  = 0;
      bus.emdop = ops[i];
      bus.ea    = as[i];
      bus.eb    = bs[i];
      if (i == 0) begin
        bus.ewreg = 1; bus.ern0 = 5'd8;
      end
      exp = {bus.ewreg, bus.em2reg, bus.ewmem, md_expect(ops[i], as[i], bs[i]), bus.eb, bus.ern0};
      #1;
      vectors++;
      if (bus.stall !== 1'b1) begin
        miscompares++;
        $display("FAIL md_stall_start[%0d]: got %b expected 1", i, bus.stall);
      end
      cnt = 0;
      while (bus.stall === 1'b1 && cnt < 40) begin
        tick();
        cnt++;
        vectors++;
        if (obs !== '0) begin
          miscompares++;
          $display("FAIL md_bubble[%0d] edge %0d: got %h expected 0", i, cnt, obs);
        end
      end
      vectors++;
      if (cnt != 33) begin
        miscompares++;
        $display("FAIL md_stall_len[%0d]: got %0d expected 33", i, cnt);
      end
      tick();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL md_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, ops[i], as[i], bs[i], obs, exp);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_op();
    int cnt;
    clear_inputs();
    bus.emdop = 2'b01; bus.ea = 32'd3; bus.eb = 32'd5; bus.ewreg = 1; bus.ern0 = 5'd2;
    #1;
    repeat (11) tick();
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_busy: got %b expected 1", bus.stall);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if (bus.stall !== 1'b0 || obs !== '0) begin
      miscompares++;
      $display("FAIL midop_reset: got stall=%b out=%h expected 0/0", bus.stall, obs);
    end
    reset = 1'b0;
    clear_inputs();
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_aborted: got stall=%b expected 0", bus.stall);
    end
    tick();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL midop_no_partial: got %h expected 0", obs);
    end
    bus.emdop = 2'b01; bus.ea = 32'd6; bus.eb = 32'd7; bus.ewreg = 1; bus.ern0 = 5'd9;
    #1;
    cnt = 0;
    while (bus.stall === 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    vectors++;
    if (cnt != 33) begin
      miscompares++;
      $display("FAIL midop_fresh_stall_len: got %0d expected 33", cnt);
    end
    tick();
    vectors++;
    if (bus.malu !== 32'd42 || bus.mrn !== 5'd9 || bus.mwreg !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_fresh_mul: got malu=%0d mrn=%0d mwreg=%b expected 42/9/1", bus.malu, bus.mrn, bus.mwreg);
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_md_back_to_back();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
